// File: rtl/fc_requant_if.sv
// Capture-side and output-stream signals of fc_requant, grouped so the
// upstream driver (master) and the requant stage (slave) see mirrored directions.
interface fc_requant_if #(
  parameter int N_PE = 16
);
  logic [N_PE*32-1:0] res_in;
  logic [N_PE*32-1:0] bias_in;
  logic               res_vld;
  logic               res_rdy;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output res_in, bias_in, res_vld, out_ready,
    input  res_rdy, out_data, out_valid, out_last
  );

  modport slave (
    input  res_in, bias_in, res_vld, out_ready,
    output res_rdy, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fc_requant.sv
// Double-banked accumulator capture, bias add + int8 requantization, serial
// show-ahead output FIFO. Define FC_REQUANT_RELU_EN to clamp at zp (fused ReLU).
module fc_requant #(
  parameter int N_PE       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  fc_requant_if.slave        bus,
  input  logic signed [31:0] m1,
  input  logic        [5:0]  s1,
  input  logic signed [7:0]  zp,
  output logic               busy,
  output logic               ovf_err
);

  localparam int          CH_W    = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CNT_W   = AW + 1;
  localparam logic [31:0] DEPTH_U = 32'(FIFO_DEPTH);

  // ---------------- capture banks ----------------
  logic signed [31:0] w_res_ch  [N_PE];
  logic signed [31:0] w_bias_ch [N_PE];
  logic signed [31:0] r_bank_res  [2][N_PE];
  logic signed [31:0] r_bank_bias [2][N_PE];
  logic [1:0]         r_full;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [CH_W-1:0]    r_ch;
  logic               r_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < N_PE; gi++) begin : g_unpack
      assign w_res_ch[gi]  = bus.res_in[32*gi +: 32];
      assign w_bias_ch[gi] = bus.bias_in[32*gi +: 32];
    end
  endgenerate

  logic w_res_rdy;
  logic w_capture;
  logic w_issue;
  logic w_last_ch;
  logic [2:0]       w_inflight;
  logic [CNT_W-1:0] w_fifo_count;

  // Pipeline valids, declared early for the issue gate.
  logic r_s1_vld, r_s2_vld, r_s3_vld, r_s4_vld;

  assign w_res_rdy  = ~r_full[r_wr_ptr];
  assign w_capture  = bus.res_vld & w_res_rdy;
  assign w_last_ch  = (r_ch == CH_W'(N_PE - 1));
  assign w_inflight = 3'(r_s1_vld) + 3'(r_s2_vld) + 3'(r_s3_vld) + 3'(r_s4_vld);
  // Reserving FIFO room for every word already in flight keeps the FIFO from overflowing.
  assign w_issue    = r_full[r_rd_ptr] &&
                      ((32'(w_fifo_count) + 32'(w_inflight)) < DEPTH_U);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_full   <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ch     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_full[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end else if (bus.res_vld) begin
        r_ovf <= 1'b1;
      end
      // A capture never targets the bank being freed: that bank is full, so res_rdy is low.
      if (w_issue) begin
        if (w_last_ch) begin
          r_full[r_rd_ptr] <= 1'b0;
          r_rd_ptr         <= ~r_rd_ptr;
          r_ch             <= '0;
        end else begin
          r_ch <= r_ch + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < N_PE; i++) begin
        r_bank_res[r_wr_ptr][i]  <= w_res_ch[i];
        r_bank_bias[r_wr_ptr][i] <= w_bias_ch[i];
      end
    end
  end

  // ---------------- S1: saturating bias add ----------------
  logic signed [31:0] w_sel_res;
  logic signed [31:0] w_sel_bias;
  logic signed [32:0] w_sum;
  logic signed [31:0] w_acc;

  assign w_sel_res  = r_bank_res[r_rd_ptr][r_ch];
  assign w_sel_bias = r_bank_bias[r_rd_ptr][r_ch];
  assign w_sum      = {w_sel_res[31], w_sel_res} + {w_sel_bias[31], w_sel_bias};

  always_comb begin
    w_acc = w_sum[31:0];
    if (w_sum[32] != w_sum[31]) begin
      w_acc = w_sum[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end
  end

  logic signed [31:0] r_s1_acc;
  logic               r_s1_last;

  // ---------------- S2: multiply ----------------
  logic signed [63:0] w_a64;
  logic signed [63:0] w_m64;
  logic signed [63:0] r_s2_prod;
  logic               r_s2_last;

  assign w_a64 = {{32{r_s1_acc[31]}}, r_s1_acc};
  assign w_m64 = {{32{m1[31]}}, m1};

  // ---------------- S3: round-half-up shift ----------------
  logic signed [64:0] w_rnd65;
  logic signed [64:0] w_sum65;
  logic signed [63:0] r_s3_r;
  logic               r_s3_last;

  assign w_rnd65 = (s1 == 6'd0) ? 65'sd0 : (65'sd1 <<< (s1 - 6'd1));
  assign w_sum65 = {r_s2_prod[63], r_s2_prod} + w_rnd65;

  // ---------------- S4: zero point and clip ----------------
  logic signed [64:0] w_t65;
  logic signed [64:0] w_lo;
  logic        [7:0]  w_q;
  logic        [7:0]  r_s4_q;
  logic               r_s4_last;

  assign w_t65 = {r_s3_r[63], r_s3_r} + {{57{zp[7]}}, zp};
`ifdef FC_REQUANT_RELU_EN
  assign w_lo  = {{57{zp[7]}}, zp};
`else
  assign w_lo  = -65'sd128;
`endif

  always_comb begin
    w_q = w_t65[7:0];
    if (w_t65 > 65'sd127) begin
      w_q = 8'd127;
    end else if (w_t65 < w_lo) begin
      w_q = w_lo[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_s4_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_issue;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      r_s4_vld <= r_s3_vld;
    end
  end

  always_ff @(posedge clk) begin
    r_s1_acc  <= w_acc;
    r_s1_last <= w_last_ch;
    r_s2_prod <= w_a64 * w_m64;
    r_s2_last <= r_s1_last;
    r_s3_r    <= 64'(w_sum65 >>> s1);
    r_s3_last <= r_s2_last;
    r_s4_q    <= w_q;
    r_s4_last <= r_s3_last;
  end

  // ---------------- show-ahead output FIFO ----------------
  // Memory plus one output register; the count covers both.
  logic [8:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_fwr;
  logic [AW-1:0]    r_frd;
  logic [CNT_W-1:0] r_mem_count;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_out_valid;
  logic             w_load;

  assign w_load       = (r_mem_count != '0) && (!r_out_valid || bus.out_ready);
  assign w_fifo_count = r_mem_count + CNT_W'(r_out_valid);

  always_ff @(posedge clk) begin
    if (r_s4_vld) begin
      r_mem[r_fwr] <= {r_s4_last, r_s4_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fwr       <= '0;
      r_frd       <= '0;
      r_mem_count <= '0;
      r_out_data  <= 8'd0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_s4_vld) begin
        r_fwr <= r_fwr + AW'(1);
      end
      if (w_load) begin
        {r_out_last, r_out_data} <= r_mem[r_frd];
        r_frd                    <= r_frd + AW'(1);
        r_out_valid              <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_mem_count <= r_mem_count + CNT_W'(r_s4_vld) - CNT_W'(w_load);
    end
  end

  assign bus.res_rdy   = w_res_rdy;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;
  assign ovf_err       = r_ovf;
  assign busy          = (|r_full) | (w_inflight != 3'd0) | (w_fifo_count != '0);

endmodule

// File: tb/tb_fc_requant.sv
// Directed bench for fc_requant (N_PE=4): scoreboard of expected int8 words
// computed from the requant arithmetic, checked on every valid output cycle.
module tb_fc_requant;
  localparam int NP = 4;
  localparam int FD = 8;

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [31:0] m1;
  logic        [5:0]  s1;
  logic signed [7:0]  zp;
  logic               busy;
  logic               ovf_err;

  fc_requant_if #(.N_PE(NP)) bus ();

  fc_requant #(.N_PE(NP), .FIFO_DEPTH(FD)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .m1      (m1),
    .s1      (s1),
    .zp      (zp),
    .busy    (busy),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit l; } word_t;
  word_t exp_q[$];
  int    got_d[$];
  bit    got_l[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    deliv   = 0;
  bit    chk_en  = 1'b0;

  task automatic check(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // Expected int8 output from the arithmetic rules, in 64-bit integer math.
  function automatic int model_q(int r, int b, int m, int s, int z);
    longint sum, acc, prod, rr, t;
    int     lo;
    sum = longint'(r) + longint'(b);
    if (sum > 64'sd2147483647) acc = 64'sd2147483647;
    else if (sum < -64'sd2147483648) acc = -64'sd2147483648;
    else acc = sum;
    prod = acc * longint'(m);
    // floor(prod / 2^s) plus the first discarded bit == round half up
    if (s == 0) rr = prod;
    else rr = (prod >>> s) + ((prod >>> (s - 1)) & 64'sd1);
`ifdef FC_REQUANT_RELU_EN
    lo = z;
`else
    lo = -128;
`endif
    t = rr + longint'(z);
    if (t > 64'sd127) return 127;
    if (t < longint'(lo)) return lo;
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int r0, input int r1, input int r2, input int r3,
                         input int b0, input int b1, input int b2, input int b3,
                         input bit accept);
    int r [NP];
    int b [NP];
    word_t w;
    r = '{r0, r1, r2, r3};
    b = '{b0, b1, b2, b3};
    for (int i = 0; i < NP; i++) begin
      bus.res_in[32*i +: 32]  = r[i];
      bus.bias_in[32*i +: 32] = b[i];
    end
    bus.res_vld = 1'b1;
    check("res_rdy_at_capture", bus.res_rdy, accept);
    if (accept) begin
      for (int i = 0; i < NP; i++) begin
        w.d = model_q(r[i], b[i], int'(m1), int'(s1), int'(zp));
        w.l = (i == NP - 1);
        exp_q.push_back(w);
      end
    end
    tick();
    bus.res_vld = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check({nm, "_drain_in_time"}, longint'(n < 400), 1);
    repeat (12) tick();
    check({nm, "_busy_idle"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_res_rdy"}, bus.res_rdy, 1);
    check({nm, "_out_valid"}, bus.out_valid, 0);
    check({nm, "_out_data"}, bus.out_data, 0);
    check({nm, "_out_last"}, bus.out_last, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_ovf_err"}, ovf_err, 0);
  endtask

  // Scoreboard: every cycle with a valid word is compared against the head.
  always @(negedge clk) begin
    if (chk_en && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got data %0d last %0d, required no word",
                 $signed(bus.out_data), bus.out_last);
      end else begin
        check("out_data", longint'($signed(bus.out_data)), exp_q[0].d);
        check("out_last", bus.out_last, exp_q[0].l);
        if (bus.out_ready) begin
          $display("word %0d: data=%0d last=%0d", deliv, $signed(bus.out_data), bus.out_last);
          got_d.push_back(int'($signed(bus.out_data)));
          got_l.push_back(bus.out_last);
          void'(exp_q.pop_front());
          deliv++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rstn = 1'b0;
    m1 = 32'sd1; s1 = 6'd0; zp = 8'sd0;
    bus.res_in = '0; bus.bias_in = '0; bus.res_vld = 1'b0; bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Model pins with hand-computed values.
    check("pin_identity", model_q(5, 0, 1, 0, 0), 5);
    check("pin_round_pos", model_q(3, 0, 1, 1, 0), 2);
    check("pin_round_neg", model_q(-3, 0, 1, 1, 0), -1);
    check("pin_round_m3", model_q(2, 0, 3, 2, 0), 2);
    check("pin_sat_hi", model_q(32'sh7fff_ffff, 10, 1, 0, 0), 127);
    check("pin_s63", model_q(32'sh8000_0000, 0, 32'sh8000_0000, 63, 0), 1);
`ifdef FC_REQUANT_RELU_EN
    check("pin_clip_lo", model_q(-1000, 0, 1, 0, 5), 5);
`else
    check("pin_clip_lo", model_q(-1000, 0, 1, 0, 5), -128);
`endif

    // Identity path and first-word latency.
    chk_en = 1'b1;
    bus.out_ready = 1'b1;
    got_d.delete(); got_l.delete();
    capture(5, -3, 100, 0, 0, 0, 0, 0, 1'b1);
    repeat (5) tick();
    check("latency_k5_valid", bus.out_valid, 0);
    tick();
    check("latency_k6_valid", bus.out_valid, 1);
    check("latency_k6_data", longint'($signed(bus.out_data)), 5);
    wait_drain("identity");
    check("identity_count", got_d.size(), 4);
    if (got_d.size() == 4) begin
      check("identity_w0", got_d[0], 5);
      check("identity_w1", got_d[1], -3);
      check("identity_w2", got_d[2], 100);
      check("identity_w3", got_d[3], 0);
      check("identity_l2", got_l[2], 0);
      check("identity_l3", got_l[3], 1);
    end

    // Rounding.
    s1 = 6'd1;
    got_d.delete(); got_l.delete();
    capture(3, -3, 7, -7, 0, 0, 0, 0, 1'b1);
    wait_drain("round_s1");
    check("round_s1_w0", got_d.size() > 0 ? got_d[0] : 999, 2);
    check("round_s1_w1", got_d.size() > 1 ? got_d[1] : 999, -1);
    m1 = 32'sd3; s1 = 6'd2;
    got_d.delete(); got_l.delete();
    capture(2, 1, -2, 100, 0, 0, 0, 0, 1'b1);
    wait_drain("round_m3");
    check("round_m3_w0", got_d.size() > 0 ? got_d[0] : 999, 2);
    check("round_m3_w3", got_d.size() > 3 ? got_d[3] : 999, 75);

    // Saturation, clipping, zero point, large shifts.
    m1 = 32'sd1; s1 = 6'd0; zp = 8'sd0;
    capture(32'sh7fff_ffff, -1000, 32'sh8000_0000, 50, 10, 0, -5, 20, 1'b1);
    wait_drain("sat");
    zp = 8'sd5;
    capture(-1000, 10, 200, -3, 0, 0, 0, 0, 1'b1);
    wait_drain("zp");
    zp = -8'sd3;
    m1 = 32'sh4000_0000; s1 = 6'd31;
    capture(3, -3, 1000, 255, 0, 0, 0, 0, 1'b1);
    wait_drain("s31");
    zp = 8'sd0;
    m1 = 32'sh8000_0000; s1 = 6'd63;
    capture(32'sh8000_0000, 0, 1, -1, 0, 0, 0, 0, 1'b1);
    wait_drain("s63");

    // Backpressure: 12 words pending against an 8-word FIFO.
    m1 = 32'sd1; s1 = 6'd0; zp = 8'sd0;
    bus.out_ready = 1'b0;
    got_d.delete(); got_l.delete();
    d0 = deliv;
    capture(11, 12, 13, 14, 0, 0, 0, 0, 1'b1);
    capture(21, 22, 23, 24, 0, 0, 0, 0, 1'b1);
    check("bp_both_banks_full_rdy", bus.res_rdy, 0);
    repeat (3) tick();
    capture(31, 32, 33, 34, 0, 0, 0, 0, 1'b1);
    repeat (20) tick();
    check("bp_stall_busy", busy, 1);
    check("bp_stall_valid", bus.out_valid, 1);
    check("bp_stall_rdy", bus.res_rdy, 1);
    bus.out_ready = 1'b1;
    wait_drain("bp");
    check("bp_count", deliv - d0, 12);
    check("bp_first", got_d.size() > 0 ? got_d[0] : 999, 11);
    check("bp_last", got_d.size() > 11 ? got_d[11] : 999, 34);
    check("bp_no_ovf", ovf_err, 0);

    // Bank overflow: third back-to-back pulse is dropped.
    bus.out_ready = 1'b0;
    d0 = deliv;
    capture(61, 62, 63, 64, 0, 0, 0, 0, 1'b1);
    capture(71, 72, 73, 74, 0, 0, 0, 0, 1'b1);
    capture(81, 82, 83, 84, 0, 0, 0, 0, 1'b0);
    check("ovf_err_set", ovf_err, 1);
    check("ovf_rdy_low", bus.res_rdy, 0);
    repeat (10) tick();
    bus.out_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_count", deliv - d0, 2 * NP);
    check("ovf_sticky", ovf_err, 1);

    // Reset while three words remain.
    bus.out_ready = 1'b0;
    capture(41, 42, 43, 44, 0, 0, 0, 0, 1'b1);
    repeat (8) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk_en = 1'b0;
    rstn = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rstn = 1'b1;
    exp_q.delete();
    got_d.delete(); got_l.delete();
    chk_en = 1'b1;
    d0 = deliv;
    bus.out_ready = 1'b1;
    capture(51, 52, 53, 54, 0, 0, 0, 0, 1'b1);
    wait_drain("post_reset");
    check("post_reset_count", deliv - d0, NP);
    check("post_reset_first", got_d.size() > 0 ? got_d[0] : 999, 51);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
